// File: rtl/bus_if.sv
// External bus interface unit. It registers core accesses and drives the address and data pads.
// It owns the data-bus tristate and adds wait states, a read->write turnaround and a ready timeout.
module bus_if #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int WS_W      = 4,
  parameter int TO_CYCLES = 255,
  parameter int TURN      = 1
) (
  input  logic            ph1,
  input  logic            reset_b,
  input  logic            core_req,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  input  logic [WS_W-1:0] wait_states,
  output logic            core_ack,
  output logic            core_err,
  output logic [DW-1:0]   core_rdata,
  output logic            busy,
  output logic [AW-1:0]   bus_addr,
  inout  wire  [DW-1:0]   bus_data,
  output logic            bus_read_en,
  input  logic            bus_rdy
);

  localparam int              TO_W    = (TO_CYCLES > 32'sd0) ? $clog2(TO_CYCLES + 32'sd1) : 32'sd1;
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [WS_W-1:0] WS_ONE  = WS_W'(1);
  localparam logic            TO_EN   = (TO_CYCLES != 32'sd0);
  localparam logic            TURN_EN = (TURN != 32'sd0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TURN = 3'd1,
    S_ADDR = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [WS_W-1:0] ws_q, ws_d;
  logic [WS_W-1:0] ws_cnt_q, ws_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            last_rd_q, last_rd_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic            read_en_q, read_en_d;
  logic            ack_q, ack_d;
  logic            cerr_q, cerr_d;
  logic            busy_q, busy_d;
  logic            timeout_s;

  // The final low-ready cycle that reaches the limit ends the access
  assign timeout_s = TO_EN && ((to_cnt_q + TO_ONE) == TO_MAX);

  // State register
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          if (TURN_EN && core_we && last_rd_q) begin
            state_d = S_TURN;
          end else begin
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN:  state_d = S_ADDR;
      S_ADDR:  state_d = S_WAIT;
      S_WAIT: begin
        if (ws_cnt_q != '0) begin
          state_d = S_WAIT;
        end else if (bus_rdy || timeout_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access datapath: captured request, counters, read data and turnaround history
  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ws_d      = ws_q;
    ws_cnt_d  = ws_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    last_rd_d = last_rd_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          addr_d  = core_addr;
          we_d    = core_we;
          wdata_d = core_wdata;
          ws_d    = wait_states;
          err_d   = 1'b0;
        end else begin
          err_d   = err_q;
        end
      end
      S_ADDR: begin
        ws_cnt_d = ws_q;
        to_cnt_d = '0;
      end
      S_WAIT: begin
        if (ws_cnt_q != '0) begin
          ws_cnt_d = ws_cnt_q - WS_ONE;
        end else if (bus_rdy) begin
          if (!we_q) begin
            rdata_d = bus_data;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          if (TO_EN) begin
            to_cnt_d = to_cnt_q + TO_ONE;
          end else begin
            to_cnt_d = to_cnt_q;
          end
          err_d = timeout_s;
        end
      end
      S_DONE:  last_rd_d = !we_q;
      S_TURN:  ws_cnt_d = ws_cnt_q;
      default: ws_cnt_d = ws_cnt_q;
    endcase
  end

  // Output logic, computed from the next state so every pin comes straight from a flop
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    ack_d      = (state_d == S_DONE);
    cerr_d     = (state_d == S_DONE) && err_d;
    read_en_d  = !(we_d && ((state_d == S_ADDR) || (state_d == S_WAIT)));
    if (state_d == S_ADDR) begin
      bus_addr_d = addr_d;
    end else begin
      bus_addr_d = bus_addr_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ws_q       <= '0;
      ws_cnt_q   <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      last_rd_q  <= 1'b1;
      rdata_q    <= '0;
      bus_addr_q <= '0;
      read_en_q  <= 1'b1;
      ack_q      <= 1'b0;
      cerr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ws_q       <= ws_d;
      ws_cnt_q   <= ws_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      last_rd_q  <= last_rd_d;
      rdata_q    <= rdata_d;
      bus_addr_q <= bus_addr_d;
      read_en_q  <= read_en_d;
      ack_q      <= ack_d;
      cerr_q     <= cerr_d;
      busy_q     <= busy_d;
    end
  end

  assign core_ack    = ack_q;
  assign core_err    = cerr_q;
  assign core_rdata  = rdata_q;
  assign busy        = busy_q;
  assign bus_addr    = bus_addr_q;
  assign bus_read_en = read_en_q;
  assign bus_data    = read_en_q ? {DW{1'bz}} : wdata_q;

endmodule
